// File: rtl/game_mode_controller_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | game_mode_controller_if                                                |
// | Button/display bundle shared between the game sequencer and the board. |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
interface game_mode_controller_if;
    logic [3:0]  btn_pulse;
    logic        switch_pulse;
    logic [15:0] game_values;
    logic [1:0]  game_sel;
    logic [15:0] game_btn;
    logic [3:0]  display_value;
    logic        dp;
    logic [1:0]  mode;

    // Environment side: pulse conditioners and game cores.
    modport master (
        output btn_pulse, switch_pulse, game_values,
        input  game_sel, game_btn, display_value, dp, mode
    );

    // Sequencer side.
    modport slave (
        input  btn_pulse, switch_pulse, game_values,
        output game_sel, game_btn, display_value, dp, mode
    );
endinterface
`default_nettype wire

// File: rtl/game_mode_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | game_mode_controller                                                   |
// | Shares one 7-seg display and four buttons between four game cores.     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module game_mode_controller #(
    parameter int SHOW_ID_CYCLES = 50000000,
    parameter int IDLE_TIMEOUT   = 500000000,
    parameter int ATTRACT_PERIOD = 25000000
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    game_mode_controller_if.slave bus
);

    localparam int SHOW_W   = $clog2(SHOW_ID_CYCLES + 1);
    localparam int IDLE_W   = $clog2(IDLE_TIMEOUT + 1);
    localparam int PERIOD_W = $clog2(ATTRACT_PERIOD + 1);

    localparam logic [SHOW_W-1:0]   SHOW_LAST   = SHOW_W'(SHOW_ID_CYCLES - 1);
    localparam logic [IDLE_W-1:0]   IDLE_LAST   = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(ATTRACT_PERIOD - 1);

    typedef enum logic [1:0] {
        MODE_SHOW_ID = 2'd0,
        MODE_PLAY    = 2'd1,
        MODE_ATTRACT = 2'd2
    } mode_e;

    mode_e               mode_q,        mode_d;
    logic [1:0]          game_sel_q,    game_sel_d;
    logic [1:0]          attract_idx_q, attract_idx_d;
    logic [SHOW_W-1:0]   show_cnt_q,    show_cnt_d;
    logic [IDLE_W-1:0]   idle_cnt_q,    idle_cnt_d;
    logic [PERIOD_W-1:0] period_cnt_q,  period_cnt_d;

    logic w_any_btn;
    logic w_fwd_btn;

    assign w_any_btn = |bus.btn_pulse;
    // A switch in PLAY wins over buttons arriving in the same cycle.
    assign w_fwd_btn = (mode_q == MODE_PLAY) && !bus.switch_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q        <= MODE_SHOW_ID;
            game_sel_q    <= 2'd0;
            attract_idx_q <= 2'd0;
            show_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            period_cnt_q  <= '0;
        end else begin
            mode_q        <= mode_d;
            game_sel_q    <= game_sel_d;
            attract_idx_q <= attract_idx_d;
            show_cnt_q    <= show_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            period_cnt_q  <= period_cnt_d;
        end
    end

    always_comb begin
        mode_d        = mode_q;
        game_sel_d    = game_sel_q;
        attract_idx_d = attract_idx_q;
        show_cnt_d    = show_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        period_cnt_d  = period_cnt_q;

        case (mode_q)
            MODE_SHOW_ID: begin
                if (bus.switch_pulse) begin
                    game_sel_d = game_sel_q + 2'd1;
                    show_cnt_d = '0;
                end else if (show_cnt_q == SHOW_LAST) begin
                    mode_d     = MODE_PLAY;
                    idle_cnt_d = '0;
                end else begin
                    show_cnt_d = show_cnt_q + 1'b1;
                end
            end
            MODE_PLAY: begin
                if (bus.switch_pulse) begin
                    game_sel_d = game_sel_q + 2'd1;
                    mode_d     = MODE_SHOW_ID;
                    show_cnt_d = '0;
                end else if (w_any_btn) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    mode_d        = MODE_ATTRACT;
                    attract_idx_d = game_sel_q;
                    period_cnt_d  = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            MODE_ATTRACT: begin
                // The waking pulse is consumed; game_sel is left untouched.
                if (w_any_btn || bus.switch_pulse) begin
                    mode_d     = MODE_SHOW_ID;
                    show_cnt_d = '0;
                end else if (period_cnt_q == PERIOD_LAST) begin
                    period_cnt_d  = '0;
                    attract_idx_d = attract_idx_q + 2'd1;
                end else begin
                    period_cnt_d = period_cnt_q + 1'b1;
                end
            end
            default: begin
                mode_d     = MODE_SHOW_ID;
                show_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        bus.display_value = {2'b00, game_sel_q} + 4'd1;
        bus.dp            = 1'b1;
        case (mode_q)
            MODE_PLAY: begin
                bus.display_value = bus.game_values[{game_sel_q, 2'b00} +: 4];
                bus.dp            = 1'b0;
            end
            MODE_ATTRACT: begin
                bus.display_value = {2'b00, attract_idx_q} + 4'd1;
                bus.dp            = attract_idx_q[0];
            end
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn_gate
        assign bus.game_btn[gi*4 +: 4] =
            (w_fwd_btn && (game_sel_q == 2'(gi))) ? bus.btn_pulse : 4'b0000;
    end

    assign bus.game_sel = game_sel_q;
    assign bus.mode     = mode_q;

endmodule
`default_nettype wire
